// File: rtl/red_peak_pkg.sv
// Shared types and defaults for the RED-channel peak/trough tracker.
package red_peak_pkg;

  localparam int DATA_W_DEF = 20;
  localparam int CNT_W_DEF  = 12;
  localparam int STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT     = 2'd0,
    ST_SEEK_MAX = 2'd1,
    ST_SEEK_MIN = 2'd2
  } state_e;

endpackage

// File: rtl/red_peak_tracker_if.sv
// Sample-in / beat-out bundle between the RED FIR filter and the peak tracker.
interface red_peak_tracker_if #(
  parameter int DATA_W = 20,
  parameter int CNT_W  = 12
);
  import red_peak_pkg::*;

  // sample_valid qualifies Filtered_Value for exactly one cycle; there is no
  // ready -- the tracker accepts a sample on every cycle sample_valid is high.
  logic              sample_valid;
  logic [DATA_W-1:0] Filtered_Value;
  logic [DATA_W-1:0] Out_RED_AC;
  logic [DATA_W-1:0] Out_RED_DC;
  logic [CNT_W-1:0]  Out_RED_Period;
  logic              beat_valid;
  logic              timeout;
  state_e            dbg_state;

  modport master (
    output sample_valid, Filtered_Value,
    input  Out_RED_AC, Out_RED_DC, Out_RED_Period, beat_valid, timeout, dbg_state
  );

  modport slave (
    input  sample_valid, Filtered_Value,
    output Out_RED_AC, Out_RED_DC, Out_RED_Period, beat_valid, timeout, dbg_state
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/red_peak_tracker.sv
// Per-beat peak/trough tracker with hysteresis producing AC, DC and beat period.
// Optional timeout / forced re-init is enabled by defining PEAK_TIMEOUT_EN.
module red_peak_tracker
  import red_peak_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int HYST       = 256,
  parameter int MIN_PERIOD = 8,
  parameter int MAX_PERIOD = 1000
) (
  input logic               CLK_Filter,
  input logic               rst,
  red_peak_tracker_if.slave bus
);

  // Hysteresis compares run one bit wider so nothing wraps near 0 or full scale.
  localparam logic [DATA_W:0] HYST_X = (DATA_W+1)'(HYST);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] max_q, max_d, min_q, min_d, peak_q, peak_d;
  logic [DATA_W-1:0] ac_q, ac_d, dc_q, dc_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic              first_q, first_d, beat_q, beat_d;
  logic [CNT_W-1:0]  cnt, per_sat;
  logic              cnt_en, cnt_clr;

  logic [DATA_W-1:0] sample;
  logic [DATA_W:0]   sample_x, max_x, min_x, dc_sum;
  logic              peak_hit, trough_hit;

  assign sample     = bus.Filtered_Value;
  assign sample_x   = {1'b0, sample};
  assign max_x      = {1'b0, max_q};
  assign min_x      = {1'b0, min_q};
  assign peak_hit   = (sample_x + HYST_X) < max_x;
  assign trough_hit = sample_x > (min_x + HYST_X);
  assign per_sat    = (&cnt) ? cnt : cnt + 1'b1;
  assign dc_sum     = {1'b0, peak_q} + min_x;

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (CLK_Filter),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (cnt)
  );

`ifdef PEAK_TIMEOUT_EN
  localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_PERIOD);
  logic to_q, to_d;
  logic cnt_hits;
  // True when this sample's increment would bring cnt to MAX_PERIOD.
  assign cnt_hits = ({1'b0, cnt} + (CNT_W+1)'(1)) == MAX_CNT;
`endif

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    peak_d  = peak_q;
    ac_d    = ac_q;
    dc_d    = dc_q;
    per_d   = per_q;
    first_d = first_q;
    beat_d  = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
`ifdef PEAK_TIMEOUT_EN
    to_d    = 1'b0;
`endif
    if (bus.sample_valid) begin
      case (state_q)
        ST_INIT: begin
          max_d   = sample;
          min_d   = sample;
          cnt_clr = 1'b1;
          state_d = ST_SEEK_MAX;
        end
        ST_SEEK_MAX: begin
          cnt_en = 1'b1;
          if (sample > max_q) begin
            max_d = sample;
          end else if (peak_hit) begin
            peak_d  = max_q;
            min_d   = sample;
            state_d = ST_SEEK_MIN;
          end
        end
        ST_SEEK_MIN: begin
          cnt_en = 1'b1;
          if (sample < min_q) begin
            min_d = sample;
          end else if (trough_hit) begin
            cnt_en  = 1'b0;
            cnt_clr = 1'b1;
            max_d   = sample;
            state_d = ST_SEEK_MAX;
            first_d = 1'b1;
            // Too-short beats still restart the period but leave outputs alone.
            if (first_q && (per_sat >= CNT_W'(MIN_PERIOD))) begin
              ac_d   = peak_q - min_q;
              dc_d   = DATA_W'(dc_sum >> 1);
              per_d  = per_sat;
              beat_d = 1'b1;
            end
          end
        end
        default: state_d = ST_INIT;
      endcase
`ifdef PEAK_TIMEOUT_EN
      if (cnt_en && cnt_hits) begin
        to_d    = 1'b1;
        state_d = ST_INIT;
        cnt_en  = 1'b0;
        cnt_clr = 1'b1;
        first_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge CLK_Filter or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      max_q   <= '0;
      min_q   <= '0;
      peak_q  <= '0;
      ac_q    <= '0;
      dc_q    <= '0;
      per_q   <= '0;
      first_q <= 1'b0;
      beat_q  <= 1'b0;
`ifdef PEAK_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      peak_q  <= peak_d;
      ac_q    <= ac_d;
      dc_q    <= dc_d;
      per_q   <= per_d;
      first_q <= first_d;
      beat_q  <= beat_d;
`ifdef PEAK_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign bus.Out_RED_AC     = ac_q;
  assign bus.Out_RED_DC     = dc_q;
  assign bus.Out_RED_Period = per_q;
  assign bus.beat_valid     = beat_q;
  assign bus.dbg_state      = state_q;
`ifdef PEAK_TIMEOUT_EN
  assign bus.timeout        = to_q;
`else
  assign bus.timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_red_peak_tracker.sv
// Bench for red_peak_tracker: directed table, hand sequences and random waves vs a reference model.
module tb_red_peak_tracker;
  import red_peak_pkg::*;

  localparam int DATA_W     = 20;
  localparam int CNT_W      = 12;
  localparam int HYST       = 256;
  localparam int MIN_PERIOD = 8;
  localparam int MAX_PERIOD = 1000;
  localparam int FULL       = (1 << DATA_W) - 1;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  red_peak_tracker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  red_peak_tracker #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .HYST(HYST),
    .MIN_PERIOD(MIN_PERIOD), .MAX_PERIOD(MAX_PERIOD)
  ) dut (
    .CLK_Filter (clk),
    .rst        (rst),
    .bus        (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int beats_seen = 0, timeouts_seen = 0, troughs_seen = 0;
  int last_ac = 0, last_dc = 0, last_per = 0;
  state_e prev_state = ST_INIT;
  int tri_pos = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase, m_max, m_min, m_peak, m_cnt, m_ac, m_dc, m_per;
  bit m_first, m_beat, m_to;
  logic [2*DATA_W+CNT_W-1:0] exp_q[$];

  function automatic void model_reset();
    m_phase = 0; m_max = 0; m_min = 0; m_peak = 0; m_cnt = 0;
    m_ac = 0; m_dc = 0; m_per = 0; m_first = 0; m_beat = 0; m_to = 0;
    exp_q.delete();
  endfunction

  function automatic int bump(int c);
    return (c < CNT_MAX) ? c + 1 : CNT_MAX;
  endfunction

  function automatic void model_step(int s);
    bit was_seeking;
    int per;
    was_seeking = (m_phase != 0);
    m_beat = 0;
    m_to   = 0;
    if (m_phase == 0) begin
      m_max = s; m_min = s; m_cnt = 0; m_phase = 1;
    end else if (m_phase == 1) begin
      m_cnt = bump(m_cnt);
      if (s > m_max) m_max = s;
      else if (s + HYST < m_max) begin
        m_peak = m_max; m_min = s; m_phase = 2;
      end
    end else begin
      if (s < m_min) begin
        m_min = s; m_cnt = bump(m_cnt);
      end else if (s > m_min + HYST) begin
        per = bump(m_cnt);
        m_cnt = 0; m_max = s; m_phase = 1;
        if (m_first && per >= MIN_PERIOD) begin
          m_ac = m_peak - m_min;
          m_dc = (m_peak + m_min) / 2;
          m_per = per;
          m_beat = 1;
          exp_q.push_back({DATA_W'(m_ac), DATA_W'(m_dc), CNT_W'(m_per)});
        end
        m_first = 1;
      end else begin
        m_cnt = bump(m_cnt);
      end
    end
`ifdef PEAK_TIMEOUT_EN
    if (was_seeking && m_cnt == MAX_PERIOD) begin
      m_to = 1; m_phase = 0; m_cnt = 0; m_first = 0;
    end
`else
    if (was_seeking) m_to = 0;
`endif
  endfunction

  function automatic state_e phase_state(int p);
    return (p == 0) ? ST_INIT : (p == 1) ? ST_SEEK_MAX : ST_SEEK_MIN;
  endfunction

  // ---------------- scoreboard / compare ----------------
  task automatic compare_outputs();
    logic [2*DATA_W+CNT_W-1:0] e;
    check("beat_valid", bus.beat_valid, m_beat);
    check("timeout", bus.timeout, m_to);
    check("ac", bus.Out_RED_AC, m_ac);
    check("dc", bus.Out_RED_DC, m_dc);
    check("period", bus.Out_RED_Period, m_per);
    check("state", int'(bus.dbg_state), int'(phase_state(m_phase)));
    if (bus.beat_valid) begin
      beats_seen++;
      last_ac = bus.Out_RED_AC; last_dc = bus.Out_RED_DC; last_per = bus.Out_RED_Period;
      check("sb_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_ac", bus.Out_RED_AC, int'(e[2*DATA_W+CNT_W-1 -: DATA_W]));
        check("sb_dc", bus.Out_RED_DC, int'(e[DATA_W+CNT_W-1 -: DATA_W]));
        check("sb_period", bus.Out_RED_Period, int'(e[CNT_W-1:0]));
      end
    end
    if (bus.timeout) timeouts_seen++;
    if (prev_state == ST_SEEK_MIN && bus.dbg_state == ST_SEEK_MAX) troughs_seen++;
    prev_state = bus.dbg_state;
  endtask

  // ---------------- drivers ----------------
  task automatic send(input int v);
    @(negedge clk);
    bus.sample_valid   = 1'b1;
    bus.Filtered_Value = DATA_W'(v);
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    model_step(v);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sample_valid   = 1'b0;
      bus.Filtered_Value = DATA_W'($urandom_range(0, FULL));
      @(posedge clk);
      #1;
      m_beat = 0; m_to = 0;
      compare_outputs();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    @(negedge clk);
    model_reset();
    compare_outputs();
    rst = 1'b0;
    prev_state = ST_INIT;
    tri_pos = 0;
  endtask

  // Triangle 1000 -> 5000 -> 1100, steps of 100, 80 samples per beat.
  task automatic send_tri(input int n);
    int k;
    repeat (n) begin
      k = tri_pos % 80;
      send((k <= 40) ? 1000 + 100 * k : 1000 + 100 * (80 - k));
      tri_pos++;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int     value;
    bit     beat;
    int     ac;
    int     dc;
    int     period;
    state_e st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int v, bit b, int ac, int dc, int p, state_e st);
    vec_t r;
    r.value = v; r.beat = b; r.ac = ac; r.dc = dc; r.period = p; r.st = st;
    return r;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int b0, t0, lo, hi, span, step, x, v, a, b;
    rst = 1'b1;
    bus.sample_valid   = 1'b0;
    bus.Filtered_Value = '0;
    model_reset();
    #12;
    compare_outputs();
    rst = 1'b0;

    // Hysteresis boundary, first-trough suppression and MIN_PERIOD edge (7 vs 8).
    vecs.push_back(mk(3000, 0, 0, 0, 0, ST_SEEK_MAX));
    vecs.push_back(mk(3200, 0, 0, 0, 0, ST_SEEK_MAX));
    vecs.push_back(mk(2944, 0, 0, 0, 0, ST_SEEK_MAX));
    vecs.push_back(mk(2943, 0, 0, 0, 0, ST_SEEK_MIN));
    vecs.push_back(mk(2800, 0, 0, 0, 0, ST_SEEK_MIN));
    vecs.push_back(mk(3056, 0, 0, 0, 0, ST_SEEK_MIN));
    vecs.push_back(mk(3057, 0, 0, 0, 0, ST_SEEK_MAX));
    vecs.push_back(mk(3400, 0, 0, 0, 0, ST_SEEK_MAX));
    vecs.push_back(mk(3143, 0, 0, 0, 0, ST_SEEK_MIN));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(2000, 0, 0, 0, 0, ST_SEEK_MIN));
    vecs.push_back(mk(2257, 0, 0, 0, 0, ST_SEEK_MAX));
    vecs.push_back(mk(3400, 0, 0, 0, 0, ST_SEEK_MAX));
    vecs.push_back(mk(3143, 0, 0, 0, 0, ST_SEEK_MIN));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(2000, 0, 0, 0, 0, ST_SEEK_MIN));
    vecs.push_back(mk(2257, 1, 1400, 2700, 8, ST_SEEK_MAX));
    vecs.push_back(mk(2257, 0, 1400, 2700, 8, ST_SEEK_MAX));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].value);
      check($sformatf("tbl_beat[%0d]", i), bus.beat_valid, vecs[i].beat);
      check($sformatf("tbl_ac[%0d]", i), bus.Out_RED_AC, vecs[i].ac);
      check($sformatf("tbl_dc[%0d]", i), bus.Out_RED_DC, vecs[i].dc);
      check($sformatf("tbl_period[%0d]", i), bus.Out_RED_Period, vecs[i].period);
      check($sformatf("tbl_state[%0d]", i), int'(bus.dbg_state), int'(vecs[i].st));
    end

    // Triangle: first trough silent, following beats AC=4000 DC=3000 Period=80.
    do_reset();
    b0 = beats_seen;
    send_tri(84);
    check("tri_first_trough_no_beat", beats_seen - b0, 0);
    send_tri(160);
    check("tri_beats", beats_seen - b0, 2);
    check("tri_ac", last_ac, 4000);
    check("tri_dc", last_dc, 3000);
    check("tri_period", last_per, 80);

    // Refractory: 6-sample beats confirm troughs but never report.
    b0 = beats_seen;
    t0 = troughs_seen;
    for (int r = 0; r < 20; r++) begin
      send(1000); send(2000); send(3000); send(3000); send(2000); send(1000);
    end
    check("refr_troughs", troughs_seen - t0, 20);
    check("refr_no_beat", beats_seen - b0, 0);
    check("refr_ac_hold", bus.Out_RED_AC, 4000);
    check("refr_dc_hold", bus.Out_RED_DC, 3000);
    check("refr_period_hold", bus.Out_RED_Period, 80);

    // Sub-hysteresis noise stays in SEEK_MAX.
    do_reset();
    b0 = beats_seen;
    x = 0;
    for (int i = 0; i < 500; i++) begin
      send((i % 2 == 0) ? 3000 : 3200);
      if (bus.dbg_state != ST_SEEK_MAX) x++;
    end
    check("noise_no_beat", beats_seen - b0, 0);
    check("noise_left_seek_max", x, 0);

    // Timeout on a flat input.
    do_reset();
    t0 = timeouts_seen;
    x = -1;
    for (int i = 1; i <= 1100; i++) begin
      send(2000);
      if (bus.timeout && x < 0) x = i;
    end
`ifdef PEAK_TIMEOUT_EN
    check("timeout_count", timeouts_seen - t0, 1);
    check("timeout_sample", x, MAX_PERIOD + 1);
`else
    check("timeout_count", timeouts_seen - t0, 0);
`endif

    // Reset asserted mid-beat while seeking a trough.
    do_reset();
    send_tri(164);
    send_tri(50);
    check("midrst_in_seek_min", int'(bus.dbg_state), int'(ST_SEEK_MIN));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_ac", bus.Out_RED_AC, 0);
    check("midrst_dc", bus.Out_RED_DC, 0);
    check("midrst_period", bus.Out_RED_Period, 0);
    check("midrst_beat", bus.beat_valid, 0);
    check("midrst_state", int'(bus.dbg_state), int'(ST_INIT));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    prev_state = ST_INIT;
    tri_pos = 0;
    b0 = beats_seen;
    send_tri(84);
    check("midrst_first_trough_no_beat", beats_seen - b0, 0);
    send_tri(80);
    check("midrst_second_beat", beats_seen - b0, 1);
    check("midrst_second_ac", last_ac, 4000);

    // Random waves across the full range with idle gaps.
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      a = $urandom_range(0, FULL);
      b = $urandom_range(0, FULL);
      if ($urandom_range(0, 3) == 0) b = a + $urandom_range(0, 600) - 300;
      if ($urandom_range(0, 5) == 0) a = 0;
      if ($urandom_range(0, 5) == 0) b = FULL;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      if (lo < 0) lo = 0;
      if (hi > FULL) hi = FULL;
      span = hi - lo;
      step = span / $urandom_range(3, 40) + 1;
      for (int dir = 0; dir < 2; dir++) begin
        x = (dir == 0) ? lo : hi;
        while ((dir == 0) ? (x <= hi) : (x >= lo)) begin
          v = x + $urandom_range(0, 300) - 150;
          if (v < 0) v = 0;
          if (v > FULL) v = FULL;
          send(v);
          if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
          x = (dir == 0) ? x + step : x - step;
        end
      end
    end
    idle(2);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
